// File: rtl/tenthirty_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tenthirty_pkg
//  Purpose  : Shared constants for the ten-and-a-half round controller:
//             FSM state encoding, result codes, score width and bust limit.
//  Revision : 1.0  initial release
// ============================================================================
package tenthirty_pkg;

    // Scores are held in half-points; 41 is the largest reachable value.
    localparam int c_PTS_W = 6;
    localparam logic [c_PTS_W-1:0] c_BUST_LIMIT = 6'd21;

    // Round outcome codes presented on `result`.
    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_ABORT  = 2'b11;

    // Round controller state encoding.
    typedef logic [3:0] state_t;
    localparam state_t c_ST_IDLE   = 4'd0;
    localparam state_t c_ST_P_REQ  = 4'd1;
    localparam state_t c_ST_P_WAIT = 4'd2;
    localparam state_t c_ST_P_DEC  = 4'd3;
    localparam state_t c_ST_D_REQ  = 4'd4;
    localparam state_t c_ST_D_WAIT = 4'd5;
    localparam state_t c_ST_D_DEC  = 4'd6;
    localparam state_t c_ST_JUDGE  = 4'd7;
    localparam state_t c_ST_DONE   = 4'd8;

endpackage
`default_nettype wire

// File: rtl/tenthirty_round_ctrl_card_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : card_decoder
//  Purpose  : Maps a 4-bit deck card to its half-point value. 1-10 score
//             twice their face value, 11-13 score one half-point, and
//             0/14/15 (empty deck or garbage) raise o_invalid.
//  Revision : 1.0  initial release
// ============================================================================
module card_decoder
    import tenthirty_pkg::*;
(
    input  logic [3:0]         i_number,
    output logic [c_PTS_W-1:0] o_half_pts,
    output logic               o_invalid
);

    // Pure lookup; shared by the player and dealer draw paths.
    always_comb begin
        o_half_pts = '0;
        o_invalid  = 1'b0;
        if (i_number == 4'd0 || i_number > 4'd13) begin
            o_invalid = 1'b1;
        end else if (i_number <= 4'd10) begin
            o_half_pts = {1'b0, i_number, 1'b0};
        end else begin
            o_half_pts = 6'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tenthirty_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tenthirty_round_ctrl
//  Purpose  : Round controller for ten-and-a-half. Requests cards from the
//             deck, accumulates player/dealer half-point scores, runs the
//             player hit/stand phase, dealer auto-draw and final judgement.
//  Options  : FIVE_CARD_WIN_EN - player reaching MAX_CARDS without busting
//             wins outright; otherwise it is treated as an implicit stand.
//  Revision : 1.0  initial release
// ============================================================================
module tenthirty_round_ctrl
    import tenthirty_pkg::*;
#(
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic               stand,
    input  logic [3:0]         number,
    output logic               pip,
    output logic [c_PTS_W-1:0] player_pts,
    output logic [c_PTS_W-1:0] dealer_pts,
    output logic [2:0]         player_cnt,
    output logic [2:0]         dealer_cnt,
    output logic [1:0]         result,
    output logic               done
);

    localparam logic [2:0]         c_MAX_CNT   = 3'(MAX_CARDS);
    localparam logic [c_PTS_W-1:0] c_D_STAND   = c_PTS_W'(DEALER_STAND);

    state_t             r_state;
    logic [c_PTS_W-1:0] r_player_pts;
    logic [c_PTS_W-1:0] r_dealer_pts;
    logic [2:0]         r_player_cnt;
    logic [2:0]         r_dealer_cnt;
    logic [1:0]         r_result;
    logic               r_done;

    logic [c_PTS_W-1:0] w_card_pts;
    logic               w_card_invalid;

    card_decoder u_card_decoder (
        .i_number   (number),
        .o_half_pts (w_card_pts),
        .o_invalid  (w_card_invalid)
    );

    // Round sequencing plus score/count/result bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_player_pts <= '0;
            r_dealer_pts <= '0;
            r_player_cnt <= '0;
            r_dealer_cnt <= '0;
            r_result     <= RES_NONE;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_player_pts <= '0;
                        r_dealer_pts <= '0;
                        r_player_cnt <= '0;
                        r_dealer_cnt <= '0;
                        r_result     <= RES_NONE;
                        r_done       <= 1'b0;
                        r_state      <= c_ST_P_REQ;
                    end
                end
                c_ST_P_REQ: r_state <= c_ST_P_WAIT;
                c_ST_P_WAIT: begin
                    if (w_card_invalid) begin
                        r_result <= RES_ABORT;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_player_pts <= r_player_pts + w_card_pts;
                        r_player_cnt <= r_player_cnt + 3'd1;
                        r_state      <= c_ST_P_DEC;
                    end
                end
                c_ST_P_DEC: begin
                    if (r_player_pts > c_BUST_LIMIT) begin
                        r_result <= RES_DEALER;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else if (r_player_cnt == c_MAX_CNT) begin
`ifdef FIVE_CARD_WIN_EN
                        r_result <= RES_PLAYER;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
`else
                        r_state  <= c_ST_D_REQ;
`endif
                    end else if (stand) begin
                        r_state <= c_ST_D_REQ;
                    end else if (hit) begin
                        r_state <= c_ST_P_REQ;
                    end
                end
                c_ST_D_REQ: r_state <= c_ST_D_WAIT;
                c_ST_D_WAIT: begin
                    if (w_card_invalid) begin
                        r_result <= RES_ABORT;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else begin
                        r_dealer_pts <= r_dealer_pts + w_card_pts;
                        r_dealer_cnt <= r_dealer_cnt + 3'd1;
                        r_state      <= c_ST_D_DEC;
                    end
                end
                c_ST_D_DEC: begin
                    if (r_dealer_pts > c_BUST_LIMIT) begin
                        r_result <= RES_PLAYER;
                        r_done   <= 1'b1;
                        r_state  <= c_ST_DONE;
                    end else if (r_dealer_pts >= c_D_STAND || r_dealer_cnt == c_MAX_CNT) begin
                        r_state <= c_ST_JUDGE;
                    end else begin
                        r_state <= c_ST_D_REQ;
                    end
                end
                c_ST_JUDGE: begin
                    // Ties go to the dealer.
                    r_result <= (r_player_pts > r_dealer_pts) ? RES_PLAYER : RES_DEALER;
                    r_done   <= 1'b1;
                    r_state  <= c_ST_DONE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Card request is a Moore decode of the two request states.
    assign pip        = (r_state == c_ST_P_REQ) || (r_state == c_ST_D_REQ);
    assign player_pts = r_player_pts;
    assign dealer_pts = r_dealer_pts;
    assign player_cnt = r_player_cnt;
    assign dealer_cnt = r_dealer_cnt;
    assign result     = r_result;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tenthirty_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tenthirty_round_ctrl
//  Purpose  : Self-checking bench for tenthirty_round_ctrl: directed rounds
//             on a fixed deck followed by random rounds scored against a
//             game-rule reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tenthirty_round_ctrl;

    localparam int MAX_CARDS    = 5;
    localparam int DEALER_STAND = 14;
    localparam int DECK_LEN     = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       stand = 1'b0;
    logic [3:0] number = 4'd0;
    logic       pip;
    logic [5:0] player_pts, dealer_pts;
    logic [2:0] player_cnt, dealer_cnt;
    logic [1:0] result;
    logic       done;

    always #5 clk = ~clk;

    tenthirty_round_ctrl #(.MAX_CARDS(MAX_CARDS), .DEALER_STAND(DEALER_STAND)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
        .number(number), .pip(pip), .player_pts(player_pts), .dealer_pts(dealer_pts),
        .player_cnt(player_cnt), .dealer_cnt(dealer_cnt), .result(result), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Deck emulation: each pip hands out the next card, held until the next pip.
    int deck [DECK_LEN];
    int deck_ptr    = 0;
    bit force_empty = 1'b0;
    int pip_cnt     = 0;
    int pip_double  = 0;
    bit pip_prev    = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (pip_prev && pip) pip_double++;
            pip_prev = pip;
            if (pip) begin
                pip_cnt++;
                number = force_empty ? 4'd0 : 4'(deck[deck_ptr % DECK_LEN]);
                deck_ptr++;
            end
        end
    end

    // Reference model: plays one round by the game rules on the same deck.
    int m_ptr = 0;
    int e_pp, e_pc, e_dp, e_dc, e_res, e_draws;

    function automatic int half(input int c);
        return (c <= 10) ? 2 * c : 1;
    endfunction

    task automatic model_round(input int hits);
        int c;
        int taken;
        e_pp = 0; e_pc = 0; e_dp = 0; e_dc = 0; e_res = 0; e_draws = 0; taken = 0;
        forever begin
            c = deck[m_ptr % DECK_LEN]; m_ptr++; e_draws++;
            if (c < 1 || c > 13) begin e_res = 3; return; end
            e_pp += half(c); e_pc++;
            if (e_pp > 21) begin e_res = 2; return; end
            if (e_pc == MAX_CARDS) begin
`ifdef FIVE_CARD_WIN_EN
                e_res = 1; return;
`else
                break;
`endif
            end
            if (taken == hits) break;
            taken++;
        end
        forever begin
            c = deck[m_ptr % DECK_LEN]; m_ptr++; e_draws++;
            if (c < 1 || c > 13) begin e_res = 3; return; end
            e_dp += half(c); e_dc++;
            if (e_dp > 21) begin e_res = 1; return; end
            if (e_dp >= DEALER_STAND || e_dc == MAX_CARDS) break;
        end
        e_res = (e_pp > e_dp) ? 1 : 2;
    endtask

    // Stimulus helpers. Each pulse leaves time for the draw to settle in P_DEC.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_act(input bit h, input bit s);
        @(negedge clk) begin hit = h; stand = s; end
        @(negedge clk) begin hit = 1'b0; stand = 1'b0; end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fresh_deck();
        int fixed [8] = '{10, 13, 8, 2, 10, 2, 7, 11};
        for (int i = 0; i < DECK_LEN; i++) deck[i] = (i < 8) ? fixed[i] : 10;
        deck_ptr = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pip"}, pip, 0);
        check({tag, "_ppts"}, player_pts, 0);
        check({tag, "_dpts"}, dealer_pts, 0);
        check({tag, "_pcnt"}, player_cnt, 0);
        check({tag, "_dcnt"}, dealer_cnt, 0);
        check({tag, "_res"}, result, 0);
        check({tag, "_done"}, done, 0);
    endtask

    int p0;

    initial begin
        fresh_deck();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // Basic win with cycle-exact timing of the first draw.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;          // cycle N+1
        check("t_pip_n1", pip, 1);
        @(negedge clk);                        // cycle N+2
        check("t_pip_n2", pip, 0);
        check("t_pts_n2", player_pts, 0);
        @(negedge clk);                        // cycle N+3
        check("t_pts_n3", player_pts, 20);
        check("t_cnt_n3", player_cnt, 1);
        pulse_act(1, 0);
        check("win_pts2", player_pts, 21);
        pulse_act(0, 1);
        wait_done("win");
        check("win_res", result, 1);
        check("win_dcnt", dealer_cnt, 1);
        check("win_dpts", dealer_pts, 16);
        check("win_done", done, 1);

        // Bust; later hit pulses must be dropped.
        do_reset(); fresh_deck(); p0 = pip_cnt;
        pulse_start(); pulse_act(1, 0); pulse_act(1, 0);
        wait_done("bust");
        check("bust_pts", player_pts, 37);
        check("bust_res", result, 2);
        check("bust_dcnt", dealer_cnt, 0);
        pulse_act(1, 0); pulse_act(0, 1);
        check("bust_pips", pip_cnt - p0, 3);
        check("bust_pcnt_hold", player_cnt, 3);

        // Simultaneous hit+stand: stand wins.
        do_reset(); fresh_deck();
        pulse_start(); pulse_act(1, 1);
        wait_done("hs");
        check("hs_pcnt", player_cnt, 1);
        check("hs_dcnt", dealer_cnt, 2);
        check("hs_dpts", dealer_pts, 17);
        check("hs_res", result, 1);

        // Empty deck on the first draw.
        do_reset(); fresh_deck(); force_empty = 1'b1;
        pulse_start();
        wait_done("empty");
        force_empty = 1'b0;
        check("empty_res", result, 3);
        check("empty_done", done, 1);
        check("empty_pts", player_pts, 0);

        // Five low cards.
        do_reset(); fresh_deck();
        deck[0] = 13; deck[1] = 11; deck[2] = 13; deck[3] = 11; deck[4] = 13; deck[5] = 10;
        p0 = pip_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) pulse_act(1, 0);
        wait_done("five");
        check("five_ppts", player_pts, 5);
        check("five_pcnt", player_cnt, 5);
`ifdef FIVE_CARD_WIN_EN
        check("five_res", result, 1);
        check("five_dcnt", dealer_cnt, 0);
        check("five_pips", pip_cnt - p0, 5);
`else
        check("five_res", result, 2);
        check("five_dcnt", dealer_cnt, 1);
        check("five_pips", pip_cnt - p0, 6);
`endif

        // Reset mid-round clears everything on the next cycle.
        do_reset(); fresh_deck();
        pulse_start(); pulse_act(1, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;

        // Random rounds on a random deck that carries over between rounds.
        do_reset();
        for (int i = 0; i < DECK_LEN; i++)
            deck[i] = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 2)) * 7 % 16 + (($urandom_range(0, 1) == 1) ? 0 : 0)
                                                    : int'($urandom_range(1, 13));
        deck_ptr = 0; m_ptr = 0;
        for (int r = 0; r < 40; r++) begin
            int hits;
            hits = int'($urandom_range(0, 5));
            model_round(hits);
            p0 = pip_cnt;
            pulse_start();
            for (int k = 0; k < hits; k++) pulse_act(1, 0);
            pulse_act(0, 1);
            wait_done($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_res", r), result, e_res);
            check($sformatf("rnd%0d_ppts", r), player_pts, e_pp);
            check($sformatf("rnd%0d_dpts", r), dealer_pts, e_dp);
            check($sformatf("rnd%0d_draws", r), pip_cnt - p0, e_draws);
            if (e_res != 3) begin
                check($sformatf("rnd%0d_pcnt", r), player_cnt, e_pc);
                check($sformatf("rnd%0d_dcnt", r), dealer_cnt, e_dc);
            end
        end

        check("pip_consecutive", pip_double, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
